// File: rtl/blake2_stream_io.sv
// rtl/blake2_stream_io.sv - W-byte command/data stream front end for the BLAKE2 core
module blake2_stream_io #(
    parameter int W           = 1,
    parameter int BLOCK_BYTES = 64,
    parameter int LL_BYTES    = 8,
    localparam int BEATS      = BLOCK_BYTES / W,
    localparam int IDX_W      = (BEATS > 1) ? $clog2(BEATS) : 1,
    localparam int NB_W       = $clog2(W) + 1,
    localparam int BB_W       = $clog2(BLOCK_BYTES) + 1,
    localparam int TT_W       = 8 * LL_BYTES,
    localparam int CFG_BYTES  = 2 + LL_BYTES,
    localparam int CB_W       = $clog2(CFG_BYTES) + 1
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              en_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [1:0]        cmd_i,
    input  logic [8*W-1:0]    data_i,
    input  logic [NB_W-1:0]   nbytes_i,
    input  logic              core_ready_i,
    input  logic              core_ack_i,
    output logic [5:0]        kk_o,
    output logic [5:0]        nn_o,
    output logic [TT_W-1:0]   ll_o,
    output logic              data_v_o,
    output logic [8*W-1:0]    data_o,
    output logic [IDX_W-1:0]  data_idx_o,
    output logic              block_done_o,
    output logic              block_first_o,
    output logic              block_last_o,
    output logic [BB_W-1:0]   blk_bytes_o,
    output logic [TT_W-1:0]   tt_o,
    output logic              err_o
);

    localparam logic [1:0] CMD_CONF  = 2'd0;
    localparam logic [1:0] CMD_START = 2'd1;
    localparam logic [1:0] CMD_DATA  = 2'd2;
    localparam logic [1:0] CMD_LAST  = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_HOLD} state_t;

    state_t           state;
    logic             en_q;
    logic [CB_W-1:0]  cfg_beat;
    logic [IDX_W-1:0] wr_idx;
    logic             acc;
    logic             is_payload;
    logic [NB_W-1:0]  n_eff;
    logic [8*W-1:0]   beat_data;
    logic [5:0]       kk_n;
    logic [5:0]       nn_n;
    logic [TT_W-1:0]  ll_n;
    int               cfg_base;

    assign ready_o    = en_q & core_ready_i & (state != S_HOLD);
    assign acc        = valid_i & ready_o;
    assign is_payload = (cmd_i == CMD_DATA) || (cmd_i == CMD_LAST);
    assign cfg_base   = int'(cfg_beat) * W;

    // Config bytes are addressed linearly across beats; anything past ll is dropped.
    always_comb begin
        kk_n = kk_o;
        nn_n = nn_o;
        ll_n = ll_o;
        for (int j = 0; j < W; j++) begin
            if (cfg_base + j == 0)
                kk_n = data_i[8*j +: 6];
            else if (cfg_base + j == 1)
                nn_n = data_i[8*j +: 6];
            else if (cfg_base + j < CFG_BYTES)
                ll_n[8*(cfg_base + j - 2) +: 8] = data_i[8*j +: 8];
        end
    end

    // Partial LAST beats are zero-padded above the valid lanes.
    always_comb begin
        n_eff     = (int'(nbytes_i) > W) ? NB_W'(W) : nbytes_i;
        beat_data = data_i;
        if (cmd_i == CMD_LAST) begin
            for (int j = 0; j < W; j++) begin
                if (j >= int'(n_eff))
                    beat_data[8*j +: 8] = 8'h00;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state         <= S_IDLE;
            en_q          <= 1'b0;
            cfg_beat      <= '0;
            wr_idx        <= '0;
            kk_o          <= '0;
            nn_o          <= '0;
            ll_o          <= '0;
            data_v_o      <= 1'b0;
            data_o        <= '0;
            data_idx_o    <= '0;
            block_done_o  <= 1'b0;
            block_first_o <= 1'b0;
            block_last_o  <= 1'b0;
            blk_bytes_o   <= '0;
            tt_o          <= '0;
            err_o         <= 1'b0;
        end else begin
            en_q         <= en_i;
            data_v_o     <= 1'b0;
            block_done_o <= 1'b0;

            if (acc) begin
                if (cmd_i == CMD_CONF) begin
                    if (state == S_IDLE) begin
                        kk_o <= kk_n;
                        nn_o <= nn_n;
                        ll_o <= ll_n;
                        if (cfg_beat != '1)
                            cfg_beat <= cfg_beat + 1'b1;
                    end else begin
                        err_o <= 1'b1;
                    end
                end else begin
                    cfg_beat <= '0;
                end
            end

            case (state)
                S_IDLE: begin
                    if (acc && cmd_i == CMD_START) begin
                        state         <= S_DATA;
                        block_first_o <= 1'b1;
                        block_last_o  <= 1'b0;
                        tt_o          <= TT_W'(W);
                        blk_bytes_o   <= BB_W'(W);
                        wr_idx        <= IDX_W'(1);
                        data_v_o      <= 1'b1;
                        data_o        <= beat_data;
                        data_idx_o    <= '0;
                    end else if (acc && is_payload) begin
                        err_o <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (acc && is_payload) begin
                        data_v_o   <= 1'b1;
                        data_o     <= beat_data;
                        data_idx_o <= wr_idx;
                        if (cmd_i == CMD_LAST) begin
                            blk_bytes_o  <= blk_bytes_o + BB_W'(n_eff);
                            tt_o         <= tt_o + TT_W'(n_eff);
                            block_last_o <= 1'b1;
                        end else begin
                            blk_bytes_o <= blk_bytes_o + BB_W'(W);
                            tt_o        <= tt_o + TT_W'(W);
                        end
                        // wr_idx parks at the final slot so it never leaves 0..BEATS-1.
                        if (cmd_i == CMD_LAST || wr_idx == IDX_W'(BEATS - 1)) begin
                            state        <= S_HOLD;
                            block_done_o <= 1'b1;
                        end else begin
                            wr_idx <= wr_idx + 1'b1;
                        end
                    end else if (acc && cmd_i == CMD_START) begin
                        err_o <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (core_ack_i) begin
                        wr_idx        <= '0;
                        blk_bytes_o   <= '0;
                        block_first_o <= 1'b0;
                        if (block_last_o) begin
                            state        <= S_IDLE;
                            block_last_o <= 1'b0;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/blake2_stream_io.md
Name: blake2_stream_io

Overview:
- Parametrised successor of the byte-serial BLAKE2 host interface. It accepts a W-byte-wide command/data stream with valid/ready backpressure and captures configuration (kk, nn, ll).
- Packs message beats into BLOCK_BYTES blocks and hands each completed block to the compression core through a hold/ack handshake.
- Tracks the total message byte count and partial final beats.
- Sits between the chip I/O pins and the BLAKE2 core.

Parameters:
- W, 1, bytes per beat; power of 2, 1..8.
- BLOCK_BYTES, 64, block size in bytes; 64 for BLAKE2s, 128 for BLAKE2b; multiple of W.
- LL_BYTES, 8, width of the ll config field in bytes; also sets the tt counter width to 8*LL_BYTES.
- Derived: BEATS = BLOCK_BYTES/W; IDX_W = clog2(BEATS); NB_W = clog2(W)+1; CFG_BYTES = 2+LL_BYTES.

Ports:
- clk, in, 1, clock.
- nreset, in, 1, synchronous active-low reset.
- en_i, in, 1, slice enable; registered internally as en_q.
- valid_i, in, 1, input beat valid.
- ready_o, in/out: out, 1, beat accepted when valid_i & ready_o.
- cmd_i, in, 2, 0=CONF, 1=START, 2=DATA, 3=LAST.
- data_i, in, 8*W, beat bytes; lane j = data_i[8j+7:8j].
- nbytes_i, in, NB_W, valid bytes on a LAST beat; lanes 0..nbytes-1.
- core_ready_i, in, 1, core able to accept data.
- core_ack_i, in, 1, core consumed the held block.
- kk_o, out, 6, key length.
- nn_o, out, 6, digest length.
- ll_o, out, 8*LL_BYTES, message length.
- data_v_o, out, 1, registered data beat valid.
- data_o, out, 8*W, registered data beat.
- data_idx_o, out, IDX_W, beat index within block for data_o.
- block_done_o, out, 1, one-cycle pulse on HOLD entry.
- block_first_o, out, 1, current block is the message's first block.
- block_last_o, out, 1, current block is the message's last block.
- blk_bytes_o, out, clog2(BLOCK_BYTES)+1, valid bytes in the current block.
- tt_o, out, 8*LL_BYTES, message bytes accepted so far.
- err_o, out, 1, sticky protocol error.

Behaviour:

Reset and enable:
- Reset values: every output 0, state IDLE, cfg counter 0, kk/nn/ll 0, en_q 0.
- Reset asserted mid-block aborts the block with no block_done_o.
- ready_o = en_q & core_ready_i & (state != HOLD); combinational from registers and core_ready_i.
- acc = valid_i & ready_o. Beats not accepted have no effect.

Configuration:
- CONF is accepted in IDLE only.
- Config byte index = cfg_beat*W + lane.
  - Index 0 = kk (bits 5:0).
  - Index 1 = nn (bits 5:0).
  - Index 2+i = ll byte i, little-endian.
  - Indices >= CFG_BYTES are ignored.
- cfg_beat saturates at its maximum value.
- cfg_beat clears on reset or on any accepted non-CONF beat.

State IDLE:
- START → DATA. Sets first=1, last=0, tt=W, blk_bytes=W, beat 0 written.
- DATA or LAST → beat dropped, err_o set, state stays IDLE.

State DATA:
- DATA: beat index +1, blk_bytes += W, tt += W.
- LAST: n = min(nbytes_i, W); blk_bytes += n; tt += n; last=1.
- CONF or START: beat dropped, err_o set.

Entering HOLD:
- Condition: the accepted beat is at index BEATS-1, or the beat is LAST.
- Next cycle: state=HOLD and block_done_o=1 for exactly one cycle.
- block_first_o, block_last_o and blk_bytes_o stay stable throughout HOLD.

State HOLD:
- ready_o=0.
- On core_ack_i: beat index=0, blk_bytes=0, first=0.
  - If last: → IDLE and last cleared.
  - Otherwise: → DATA.
- core_ack_i outside HOLD is ignored.

A single-beat block (START received as LAST-equivalent) is not allowed: a LAST must follow START.

Datapath and counters:
- data_v_o = acc of a START/DATA/LAST beat, delayed 1 cycle.
- data_o and data_idx_o are registered together with data_v_o.
- Lanes >= nbytes on a LAST beat are forced to 0x00 (zero-pad).
- tt wraps modulo 2^(8*LL_BYTES).
- The beat index never exceeds BEATS-1.
- err_o clears only on reset.

Test Plan:
- W=4, BLOCK_BYTES=64. CONF beats with lanes (0x00,0x20,0x41,0x00), (0,0,0,0), (0,0,0xFF,0xFF) → kk_o=0, nn_o=0x20, ll_o=0x41; lanes beyond index 9 are ignored.
- START + 15 DATA beats with core_ready_i=1 → data_idx_o runs 0..15; block_done_o pulses once; first=1, last=0, blk_bytes_o=64; ready_o=0 until core_ack_i; after the ack, block_first_o=0.
- Second block: START-block ack, then DATA, DATA, LAST with nbytes_i=1, data_i=0xDDCCBBAA → data_o=0x000000AA, blk_bytes_o=9, block_last_o=1, tt_o=73; after core_ack_i the state returns to IDLE and ready_o=1.
- DATA while IDLE → err_o=1, data_v_o stays 0, tt_o unchanged. START during DATA → err_o=1 and the beat index is unchanged.
- en_i=0 or core_ready_i=0 with valid_i=1 → ready_o=0, no state change. nreset low at beat 7 → all outputs 0 and IDLE the next cycle.
- LL_BYTES=1 with tt near wrap: 256+ bytes accepted → tt_o wraps modulo 256.
